// File: rtl/maxpool_relu_stream.sv
// Streaming ReLU followed by 2x2 max-pooling over raster-ordered half-precision pixels.
// One pooled pixel leaves per 2x2 window, one cycle after the window's last pixel is accepted.
module maxpool_relu_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int H          = 28,
  parameter int W          = 28
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  frame_done
);

  localparam int CW  = $clog2(W);
  localparam int RW  = $clog2(H);
  localparam int LBW = (W > 2) ? $clog2(W / 2) : 1;
  localparam int LBD = 2 ** LBW;

  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_pair;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_frame_done;
  logic                  r_last_pending;
  logic [DATA_WIDTH-1:0] r_linebuf [LBD];

  logic                  w_in_xfer;
  logic                  w_out_xfer;
  logic                  w_col_last;
  logic                  w_row_last;
  logic [LBW-1:0]        w_lb_idx;
  logic [DATA_WIDTH-1:0] w_relu;
  logic [DATA_WIDTH-1:0] w_lb_rd;
  logic [DATA_WIDTH-1:0] w_pair_max;
  logic [DATA_WIDTH-1:0] w_win_max;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;
  assign w_col_last = (r_col == CW'(W - 1));
  assign w_row_last = (r_row == RW'(H - 1));
  assign w_lb_idx   = LBW'(r_col >> 1);

  // Any pattern with the sign bit set, including -0 and negative NaN, clamps to +0.
  assign w_relu     = in_data[DATA_WIDTH-1] ? '0 : in_data;
  assign w_lb_rd    = r_linebuf[w_lb_idx];
  // Non-negative half-precision patterns order the same as unsigned integers.
  assign w_pair_max = (w_relu > r_pair) ? w_relu : r_pair;
  assign w_win_max  = (w_lb_rd > w_pair_max) ? w_lb_rd : w_pair_max;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col          <= '0;
      r_row          <= '0;
      r_pair         <= '0;
      r_out_data     <= '0;
      r_out_valid    <= 1'b0;
      r_frame_done   <= 1'b0;
      r_last_pending <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_out_xfer) begin
        r_out_valid <= 1'b0;
        if (r_last_pending) begin
          r_frame_done   <= 1'b1;
          r_last_pending <= 1'b0;
        end
      end
      if (w_in_xfer) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
        if (!r_col[0]) begin
          r_pair <= w_relu;
        end else if (r_row[0]) begin
          // A load on the same edge as a handoff wins, keeping full-rate streams unstalled.
          r_out_data     <= w_win_max;
          r_out_valid    <= 1'b1;
          r_last_pending <= w_col_last && w_row_last;
        end
      end
    end
  end

  // Line buffer needs no reset: every entry is rewritten on an even row before it is read.
  always_ff @(posedge clk) begin
    if (w_in_xfer && r_col[0] && !r_row[0]) begin
      r_linebuf[w_lb_idx] <= w_pair_max;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_maxpool_relu_stream.sv
// Bench for maxpool_relu_stream on a 4x4 frame: a frame-level pooling model checked every cycle,
// plus literal expectations for hand-worked frames.
module tb_maxpool_relu_stream;

  localparam int TH = 4;
  localparam int TW = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        frame_done;

  maxpool_relu_stream #(.DATA_WIDTH(16), .H(TH), .W(TW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    bit          last;
  } res_t;

  int          n_total = 0;
  int          n_pass  = 0;
  res_t        q[$];
  logic [15:0] obs[$];
  logic [15:0] mpix [TH*TW];
  int          mn = 0;
  bit          fd_exp = 0;
  bit          prev_stall = 0;
  logic [15:0] prev_data = '0;
  int          fd_count = 0;
  int          n_stall = 0;
  int          n_stall_xfer = 0;
  int          n_coincide = 0;
  int          rmode = 0;
  bit          arm_stall = 0;
  int          stall_cnt = 0;

  logic [15:0] lit1 [4] = '{16'h4000, 16'h3C00, 16'h3C00, 16'h3C00};
  logic [15:0] lit3 [4] = '{16'h3C05, 16'h3C07, 16'h3C0C, 16'h3C0F};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [15:0] relu(input logic [15:0] x);
    return x[15] ? 16'h0000 : x;
  endfunction

  function automatic logic [15:0] mx(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? a : b;
  endfunction

  // Frame-level model: pixels are stored by raster index; a window result is due
  // whenever the accepted pixel is the bottom-right corner of a 2x2 block.
  task automatic model_accept(input logic [15:0] d);
    int r, c;
    res_t e;
    mpix[mn] = d;
    r = mn / TW;
    c = mn % TW;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      e.d = mx(mx(relu(mpix[(r-1)*TW + c-1]), relu(mpix[(r-1)*TW + c])),
               mx(relu(mpix[r*TW + c-1]), relu(mpix[r*TW + c])));
      e.last = (mn == TH*TW - 1);
      q.push_back(e);
    end
    mn = (mn == TH*TW - 1) ? 0 : mn + 1;
  endtask

  // Inputs change only just after a rising edge, so the negedge view predicts the next edge.
  always @(negedge clk) begin
    res_t e;
    if (frame_done) fd_count++;
    if (reset) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_in_ready", in_ready, 1);
      q.delete();
      mn = 0;
      fd_exp = 0;
      prev_stall = 0;
    end else begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      chk("out_valid", out_valid, q.size() > 0);
      if (out_valid && q.size() > 0) chk("out_data", out_data, q[0].d);
      chk("frame_done", frame_done, fd_exp);
      if (prev_stall) begin
        chk("stall_valid_held", out_valid, 1);
        chk("stall_data_held", out_data, prev_data);
      end
      fd_exp = 0;
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        obs.push_back(out_data);
        if (e.last) fd_exp = 1;
      end
      if (out_valid && !out_ready) begin
        n_stall++;
        if (in_valid && in_ready) n_stall_xfer++;
      end
      if (out_valid && out_ready && in_valid && in_ready) n_coincide++;
      if (in_valid && in_ready) model_accept(in_data);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  always @(posedge clk) begin
    #1;
    case (rmode)
      1: out_ready = 1'($urandom_range(0, 1));
      2: begin
        if (arm_stall && out_valid) begin
          arm_stall = 0;
          stall_cnt = 5;
        end
        if (stall_cnt > 0) begin
          out_ready = 1'b0;
          stall_cnt--;
        end else begin
          out_ready = 1'b1;
        end
      end
      default: out_ready = 1'b1;
    endcase
  end

  task automatic send_px(input logic [15:0] d);
    int  guard;
    bit  done;
    guard = 0;
    done  = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (!done && guard > 200) begin
        chk("input_accept_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q.size() > 0 || out_valid) && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 100) chk("drain_timeout", 0, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame3();
    for (int i = 0; i < TH*TW; i++) send_px((i == 13) ? 16'hC000 : 16'h3C00 + 16'(i));
  endtask

  initial begin
    int fd0, st0, co0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Single bright pixel in the first window.
    obs.delete();
    fd0 = fd_count;
    for (int i = 0; i < TH*TW; i++) send_px((i == 5) ? 16'h4000 : 16'h3C00);
    drain();
    chk("t1_count", obs.size(), 4);
    for (int k = 0; k < 4 && k < obs.size(); k++) chk("t1_literal", obs[k], lit1[k]);
    chk("t1_frame_done", fd_count - fd0, 1);

    // Negatives and negative zero all clamp to zero.
    obs.delete();
    for (int i = 0; i < TH*TW; i++) send_px((i == 9) ? 16'h8000 : 16'hBC00);
    drain();
    chk("t2_count", obs.size(), 4);
    for (int k = 0; k < obs.size(); k++) chk("t2_literal", obs[k], 16'h0000);

    // Five-cycle downstream stall right after the first result.
    obs.delete();
    st0 = n_stall;
    rmode = 2;
    arm_stall = 1;
    send_frame3();
    drain();
    rmode = 0;
    chk("t3_stall_cycles", n_stall - st0, 5);
    chk("t3_no_input_in_stall", n_stall_xfer, 0);
    chk("t3_count", obs.size(), 4);
    for (int k = 0; k < 4 && k < obs.size(); k++) chk("t3_literal", obs[k], lit3[k]);

    // Two back-to-back random frames with input gaps and random downstream readiness.
    obs.delete();
    fd0 = fd_count;
    rmode = 1;
    for (int i = 0; i < 2*TH*TW; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_px(16'($urandom));
    end
    drain();
    rmode = 0;
    chk("t4_count", obs.size(), 8);
    chk("t4_frame_done", fd_count - fd0, 2);

    // Reset after six pixels, then one clean frame.
    for (int i = 0; i < 6; i++) send_px(16'h7000);
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    obs.delete();
    fd0 = fd_count;
    send_frame3();
    drain();
    chk("t5_count", obs.size(), 4);
    for (int k = 0; k < 4 && k < obs.size(); k++) chk("t5_literal", obs[k], lit3[k]);
    chk("t5_frame_done", fd_count - fd0, 1);

    // Full-rate stream: handoffs share edges with input accepts.
    obs.delete();
    co0 = n_coincide;
    for (int i = 0; i < TH*TW; i++) send_px(16'($urandom_range(0, 16'hFFFF)));
    drain();
    chk("t6_count", obs.size(), 4);
    chk("t6_same_edge_seen", (n_coincide - co0) > 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
